// File: rtl/ethernet_udp_receive.sv
// ethernet_udp_receive
// Receive side of the MII Ethernet/UDP link. The PHY receive pins are
// oversampled on the system clock: rx_clk is synchronized and treated as
// data, and a nibble is taken on each synchronized 0->1 transition. The
// receiver hunts for preamble/SFD and parses the Ethernet II, IPv4 and UDP
// headers. It accepts a frame only when the destination MAC, IP and UDP port
// all match the local ones. It then streams the UDP payload and reports the
// CRC-32 status when the frame ends.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   eth_rx_clk/dv/d        raw MII receive pins (rx_clk treated as data)
//   local_mac/ip/port      destination filter (broadcast MAC always accepted)
//   data/data_valid/last   payload byte stream, one-cycle strobes
//   src_mac/ip/port        sender identity of the current accepted frame
//   frame_done/frame_ok    end-of-frame strobe and its good/bad status
module ethernet_udp_receive #(
    parameter int MAX_BYTES = 256,
    parameter int SYNC      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eth_rx_clk,
    input  logic        eth_rx_dv,
    input  logic [3:0]  eth_rx_d,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [15:0] local_port,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        data_last,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic        frame_done,
    output logic        frame_ok
);

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] HDR_LAST    = 16'd41;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_PAYLOAD,
        S_TRAIL,
        S_DROP
    } state_t;

    // Bit-serial reflected CRC-32 step for one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  byte_in);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ byte_in[i]) c = (c >> 1) ^ 32'hEDB88320;
            else                   c = c >> 1;
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizers. All three pins go through the same depth so the
    // nibble and dv seen at the rx_clk edge belong together. These flops
    // are deliberately not reset so that rx_dv is still tracked while
    // reset is held in the middle of a frame.
    // ------------------------------------------------------------------
    logic [SYNC-1:0] rx_clk_sync_q;
    logic [SYNC-1:0] rx_dv_sync_q;
    logic [3:0]      rx_d_sync_q [SYNC];
    logic            rx_clk_prev_q;

    always_ff @(posedge clk) begin
        rx_clk_sync_q[0] <= eth_rx_clk;
        rx_dv_sync_q[0]  <= eth_rx_dv;
        rx_d_sync_q[0]   <= eth_rx_d;
        for (int i = 1; i < SYNC; i++) begin
            rx_clk_sync_q[i] <= rx_clk_sync_q[i-1];
            rx_dv_sync_q[i]  <= rx_dv_sync_q[i-1];
            rx_d_sync_q[i]   <= rx_d_sync_q[i-1];
        end
        rx_clk_prev_q <= rx_clk_sync_q[SYNC-1];
    end

    logic       rx_clk_s;
    logic       rx_dv_s;
    logic [3:0] rx_d_s;
    logic       nib_stb;
    logic       byte_stb;
    logic [7:0] byte_val;

    assign rx_clk_s = rx_clk_sync_q[SYNC-1];
    assign rx_dv_s  = rx_dv_sync_q[SYNC-1];
    assign rx_d_s   = rx_d_sync_q[SYNC-1];
    assign nib_stb  = rx_clk_s & ~rx_clk_prev_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        armed_q, armed_d;        // rx_dv low seen since reset
    logic        phase_q, phase_d;        // 1: low nibble held, waiting for high
    logic [3:0]  low_nib_q, low_nib_d;
    logic [15:0] cnt_q, cnt_d;            // header index, then payload index
    logic [15:0] pay_len_q, pay_len_d;
    logic [2:0]  trail_q, trail_d;        // trailing bytes, saturates at 4
    logic [31:0] crc_q, crc_d;

    // Header fields captured as they stream past
    logic [47:0] hdst_mac_q, hdst_mac_d;
    logic [47:0] hsrc_mac_q, hsrc_mac_d;
    logic [15:0] etype_q, etype_d;
    logic [7:0]  ver_ihl_q, ver_ihl_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] hsrc_ip_q, hsrc_ip_d;
    logic [31:0] hdst_ip_q, hdst_ip_d;
    logic [15:0] hsrc_port_q, hsrc_port_d;
    logic [15:0] hdst_port_q, hdst_port_d;
    logic [15:0] ulen_q, ulen_d;

    // Registered outputs
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        data_last_q, data_last_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [15:0] src_port_q, src_port_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_ok_q, frame_ok_d;

    assign byte_stb = nib_stb & rx_dv_s & phase_q;
    assign byte_val = {rx_d_s, low_nib_q};

    logic hdr_ok;
    assign hdr_ok = ((hdst_mac_q == local_mac) || (hdst_mac_q == 48'hFFFF_FFFF_FFFF))
                 && (etype_q == 16'h0800)
                 && (ver_ihl_q == 8'h45)
                 && (proto_q == 8'd17)
                 && (hdst_ip_q == local_ip)
                 && (hdst_port_q == local_port)
                 && (ulen_q >= 16'd8)
                 && (ulen_q <= 16'(MAX_BYTES + 8));

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        phase_d      = phase_q;
        low_nib_d    = low_nib_q;
        cnt_d        = cnt_q;
        pay_len_d    = pay_len_q;
        trail_d      = trail_q;
        crc_d        = crc_q;
        hdst_mac_d   = hdst_mac_q;
        hsrc_mac_d   = hsrc_mac_q;
        etype_d      = etype_q;
        ver_ihl_d    = ver_ihl_q;
        proto_d      = proto_q;
        hsrc_ip_d    = hsrc_ip_q;
        hdst_ip_d    = hdst_ip_q;
        hsrc_port_d  = hsrc_port_q;
        hdst_port_d  = hdst_port_q;
        ulen_d       = ulen_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        data_last_d  = 1'b0;
        src_mac_d    = src_mac_q;
        src_ip_d     = src_ip_q;
        src_port_d   = src_port_q;
        frame_done_d = 1'b0;
        frame_ok_d   = 1'b0;

        // Nibble pairing is shared by every state that lives after the SFD.
        if ((state_q == S_HEADER || state_q == S_PAYLOAD || state_q == S_TRAIL)
                && rx_dv_s && nib_stb) begin
            phase_d = ~phase_q;
            if (!phase_q) low_nib_d = rx_d_s;
        end

        // The whole post-SFD byte stream, FCS included, feeds the CRC.
        if ((state_q == S_HEADER || state_q == S_PAYLOAD || state_q == S_TRAIL) && byte_stb)
            crc_d = crc32_byte(crc_q, byte_val);

        case (state_q)
            S_IDLE: begin
                if (!rx_dv_s) begin
                    armed_d = 1'b1;
                end else if (nib_stb && armed_q) begin
                    state_d = (rx_d_s == 4'h5) ? S_PREAMBLE : S_DROP;
                end
            end

            S_PREAMBLE: begin
                if (!rx_dv_s) begin
                    state_d = S_IDLE;
                end else if (nib_stb) begin
                    // Preamble nibbles are all 5, so a D here completes 0xD5.
                    // Byte phase restarts from the first nibble after it.
                    if (rx_d_s == 4'hD) begin
                        state_d = S_HEADER;
                        phase_d = 1'b0;
                        cnt_d   = '0;
                        crc_d   = 32'hFFFF_FFFF;
                    end else if (rx_d_s != 4'h5) begin
                        state_d = S_DROP;
                    end
                end
            end

            S_HEADER: begin
                if (!rx_dv_s) begin
                    state_d = S_IDLE;
                    phase_d = 1'b0;
                end else if (byte_stb) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q < 16'd6)
                        hdst_mac_d = {hdst_mac_q[39:0], byte_val};
                    else if (cnt_q < 16'd12)
                        hsrc_mac_d = {hsrc_mac_q[39:0], byte_val};
                    else if (cnt_q < 16'd14)
                        etype_d = {etype_q[7:0], byte_val};
                    else if (cnt_q == 16'd14)
                        ver_ihl_d = byte_val;
                    else if (cnt_q == 16'd23)
                        proto_d = byte_val;
                    else if (cnt_q >= 16'd26 && cnt_q < 16'd30)
                        hsrc_ip_d = {hsrc_ip_q[23:0], byte_val};
                    else if (cnt_q >= 16'd30 && cnt_q < 16'd34)
                        hdst_ip_d = {hdst_ip_q[23:0], byte_val};
                    else if (cnt_q >= 16'd34 && cnt_q < 16'd36)
                        hsrc_port_d = {hsrc_port_q[7:0], byte_val};
                    else if (cnt_q >= 16'd36 && cnt_q < 16'd38)
                        hdst_port_d = {hdst_port_q[7:0], byte_val};
                    else if (cnt_q >= 16'd38 && cnt_q < 16'd40)
                        ulen_d = {ulen_q[7:0], byte_val};

                    // Last UDP checksum byte: every checked field is in place.
                    if (cnt_q == HDR_LAST) begin
                        if (hdr_ok) begin
                            src_mac_d  = hsrc_mac_q;
                            src_ip_d   = hsrc_ip_q;
                            src_port_d = hsrc_port_q;
                            pay_len_d  = ulen_q - 16'd8;
                            cnt_d      = '0;
                            trail_d    = '0;
                            state_d    = (ulen_q == 16'd8) ? S_TRAIL : S_PAYLOAD;
                        end else begin
                            state_d = S_DROP;
                        end
                    end
                end
            end

            S_PAYLOAD: begin
                if (!rx_dv_s) begin
                    // Frame ended before the UDP length was satisfied.
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                    phase_d      = 1'b0;
                end else if (byte_stb) begin
                    data_d       = byte_val;
                    data_valid_d = 1'b1;
                    cnt_d        = cnt_q + 16'd1;
                    if (cnt_q == pay_len_q - 16'd1) begin
                        data_last_d = 1'b1;
                        state_d     = S_TRAIL;
                    end
                end
            end

            S_TRAIL: begin
                if (!rx_dv_s) begin
                    frame_done_d = 1'b1;
                    frame_ok_d   = (crc_q == CRC_RESIDUE) && (trail_q >= 3'd4) && !phase_q;
                    state_d      = S_IDLE;
                    phase_d      = 1'b0;
                end else if (byte_stb && trail_q < 3'd4) begin
                    trail_d = trail_q + 3'd1;
                end
            end

            S_DROP: begin
                if (!rx_dv_s) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            armed_q      <= 1'b0;
            phase_q      <= 1'b0;
            low_nib_q    <= '0;
            cnt_q        <= '0;
            pay_len_q    <= '0;
            trail_q      <= '0;
            crc_q        <= 32'hFFFF_FFFF;
            hdst_mac_q   <= '0;
            hsrc_mac_q   <= '0;
            etype_q      <= '0;
            ver_ihl_q    <= '0;
            proto_q      <= '0;
            hsrc_ip_q    <= '0;
            hdst_ip_q    <= '0;
            hsrc_port_q  <= '0;
            hdst_port_q  <= '0;
            ulen_q       <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
            src_mac_q    <= '0;
            src_ip_q     <= '0;
            src_port_q   <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            phase_q      <= phase_d;
            low_nib_q    <= low_nib_d;
            cnt_q        <= cnt_d;
            pay_len_q    <= pay_len_d;
            trail_q      <= trail_d;
            crc_q        <= crc_d;
            hdst_mac_q   <= hdst_mac_d;
            hsrc_mac_q   <= hsrc_mac_d;
            etype_q      <= etype_d;
            ver_ihl_q    <= ver_ihl_d;
            proto_q      <= proto_d;
            hsrc_ip_q    <= hsrc_ip_d;
            hdst_ip_q    <= hdst_ip_d;
            hsrc_port_q  <= hsrc_port_d;
            hdst_port_q  <= hdst_port_d;
            ulen_q       <= ulen_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            data_last_q  <= data_last_d;
            src_mac_q    <= src_mac_d;
            src_ip_q     <= src_ip_d;
            src_port_q   <= src_port_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign data_last  = data_last_q;
    assign src_mac    = src_mac_q;
    assign src_ip     = src_ip_q;
    assign src_port   = src_port_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;

endmodule

// File: tb/tb_ethernet_udp_receive.sv
// Bench for ethernet_udp_receive: builds whole Ethernet/IPv4/UDP frames,
// drives them nibble by nibble at 25 MHz MII timing, and compares the
// received payload stream and end-of-frame status with what the frame
// contents imply.
`timescale 1ns/1ps
module tb_ethernet_udp_receive;

    localparam int          MAX_BYTES = 256;
    localparam logic [47:0] LMAC      = 48'h02_00_00_00_00_01;
    localparam logic [31:0] LIP       = 32'h0A_00_00_02;
    localparam logic [15:0] LPORT     = 16'd5000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        eth_rx_clk = 1'b0;
    logic        eth_rx_dv = 1'b0;
    logic [3:0]  eth_rx_d = 4'h0;
    logic [47:0] local_mac = LMAC;
    logic [31:0] local_ip = LIP;
    logic [15:0] local_port = LPORT;
    logic [7:0]  data;
    logic        data_valid;
    logic        data_last;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic        frame_done;
    logic        frame_ok;

    always #5 clk = ~clk;

    ethernet_udp_receive #(.MAX_BYTES(MAX_BYTES), .SYNC(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .eth_rx_clk (eth_rx_clk),
        .eth_rx_dv  (eth_rx_dv),
        .eth_rx_d   (eth_rx_d),
        .local_mac  (local_mac),
        .local_ip   (local_ip),
        .local_port (local_port),
        .data       (data),
        .data_valid (data_valid),
        .data_last  (data_last),
        .src_mac    (src_mac),
        .src_ip     (src_ip),
        .src_port   (src_port),
        .frame_done (frame_done),
        .frame_ok   (frame_ok)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling clock edge.
    logic [7:0] got_d[$];
    logic       got_l[$];
    int         fd_cnt = 0;
    int         clash_cnt = 0;
    logic       fd_ok = 1'b0;

    always @(negedge clk) begin
        if (data_valid) begin
            got_d.push_back(data);
            got_l.push_back(data_last);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_ok = frame_ok;
        end
        if ((data_valid && frame_done) || (data_last && !data_valid) || (frame_ok && !frame_done))
            clash_cnt++;
    end

    typedef struct {
        logic [47:0] dmac;
        logic [47:0] smac;
        logic [15:0] etype;
        logic [7:0]  verihl;
        logic [7:0]  proto;
        logic [31:0] sip;
        logic [31:0] dip;
        logic [15:0] sport;
        logic [15:0] dport;
        logic [15:0] ulen;
    } hdr_t;

    logic [7:0] pay[$];   // UDP payload of the frame being built
    logic [7:0] fb[$];    // post-SFD bytes of the frame, FCS included

    function automatic hdr_t good_hdr(input logic [15:0] ulen);
        hdr_t h;
        h.dmac   = LMAC;
        h.smac   = 48'h00_11_22_33_44_55;
        h.etype  = 16'h0800;
        h.verihl = 8'h45;
        h.proto  = 8'd17;
        h.sip    = 32'h0A_00_00_01;
        h.dip    = LIP;
        h.sport  = 16'd1234;
        h.dport  = LPORT;
        h.ulen   = ulen;
        return h;
    endfunction

    // Ethernet FCS: CRC-32 over the bytes so far, whole byte folded in first.
    function automatic logic [31:0] fcs_of_fb();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (fb[k]) begin
            c = c ^ {24'h0, fb[k]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push16(input logic [15:0] v);
        fb.push_back(v[15:8]);
        fb.push_back(v[7:0]);
    endtask

    task automatic build(input hdr_t h);
        logic [31:0] fcs;
        fb.delete();
        for (int i = 5; i >= 0; i--) fb.push_back(h.dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(h.smac[8*i +: 8]);
        push16(h.etype);
        fb.push_back(h.verihl);
        fb.push_back(8'h00);
        push16(h.ulen + 16'd20);
        push16(16'h0000);
        push16(16'h4000);
        fb.push_back(8'd64);
        fb.push_back(h.proto);
        push16(16'h0000);
        for (int i = 3; i >= 0; i--) fb.push_back(h.sip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) fb.push_back(h.dip[8*i +: 8]);
        push16(h.sport);
        push16(h.dport);
        push16(h.ulen);
        push16(16'h0000);
        foreach (pay[k]) fb.push_back(pay[k]);
        while (fb.size() < 60) fb.push_back(8'h00);
        fcs = fcs_of_fb();
        for (int i = 0; i < 4; i++) fb.push_back(fcs[8*i +: 8]);
    endtask

    // One MII nibble: data changes with rx_clk low, PHY clock period 40 ns.
    task automatic nib(input logic dv, input logic [3:0] n);
        eth_rx_clk = 1'b0;
        eth_rx_dv  = dv;
        eth_rx_d   = n;
        #20;
        eth_rx_clk = 1'b1;
        #20;
    endtask

    task automatic send(input int cut, input bit odd, input int rst_nib);
        logic [7:0] b;
        repeat (4) nib(1'b0, 4'h0);
        repeat (15) nib(1'b1, 4'h5);
        nib(1'b1, 4'hD);
        for (int k = 0; k < cut; k++) begin
            b = fb[k];
            for (int h = 0; h < 2; h++) begin
                if (2*k + h == rst_nib) reset = 1'b1;
                nib(1'b1, (h == 0) ? b[3:0] : b[7:4]);
                reset = 1'b0;
            end
        end
        if (odd) nib(1'b1, 4'hA);
        repeat (10) nib(1'b0, 4'h0);
    endtask

    // Send one frame and compare against what its contents call for.
    // cut_pay < 0 sends the whole frame, otherwise dv drops after that many
    // payload bytes. rst_nib >= 0 pulses reset at that post-SFD nibble.
    task automatic run(input string name, input hdr_t h, input int cut_pay,
                       input bit corrupt, input bit odd, input int rst_nib);
        int  base_d;
        int  base_fd;
        int  cut;
        int  exp_n;
        int  got_n;
        bit  acc;
        bit  complete;
        bit  exp_ok;
        base_d  = got_d.size();
        base_fd = fd_cnt;
        build(h);
        if (corrupt) fb[fb.size()-1] = fb[fb.size()-1] ^ 8'h01;
        cut = (cut_pay < 0) ? fb.size() : 42 + cut_pay;
        send(cut, odd, rst_nib);

        acc = ((h.dmac == LMAC) || (h.dmac == 48'hFFFF_FFFF_FFFF))
           && (h.etype == 16'h0800) && (h.verihl == 8'h45) && (h.proto == 8'd17)
           && (h.dip == LIP) && (h.dport == LPORT)
           && (h.ulen >= 16'd8) && (int'(h.ulen) <= MAX_BYTES + 8)
           && (rst_nib < 0);
        complete = (cut_pay < 0);
        exp_n    = !acc ? 0 : (complete ? int'(h.ulen) - 8 : cut_pay);
        exp_ok   = acc && complete && !corrupt && !odd;

        got_n = got_d.size() - base_d;
        check({name, ".count"}, 64'(got_n), 64'(exp_n));
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            check({name, ".data"}, 64'(got_d[base_d+i]), 64'(pay[i]));
            check({name, ".last"}, 64'(got_l[base_d+i]), 64'(complete && (i == exp_n - 1)));
        end
        check({name, ".done"}, 64'(fd_cnt - base_fd), 64'(acc ? 1 : 0));
        if (acc) check({name, ".ok"}, 64'(fd_ok), 64'(exp_ok));
        if (exp_n > 0) begin
            check({name, ".src_mac"}, 64'(src_mac), 64'(h.smac));
            check({name, ".src_ip"}, 64'(src_ip), 64'(h.sip));
            check({name, ".src_port"}, 64'(src_port), 64'(h.sport));
        end
        $display("frame %s ulen=%0d bytes=%0d/%0d done=%0d ok=%0d",
                 name, h.ulen, got_n, exp_n, fd_cnt - base_fd, fd_ok);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        hdr_t h;
        int   kind;
        int   cp;
        bit   cor;
        bit   odd;

        repeat (4) nib(1'b0, 4'h0);
        reset = 1'b0;
        repeat (2) nib(1'b0, 4'h0);
        check("rst.data_valid", 64'(data_valid), 64'd0);
        check("rst.data_last", 64'(data_last), 64'd0);
        check("rst.frame_done", 64'(frame_done), 64'd0);
        check("rst.frame_ok", 64'(frame_ok), 64'd0);
        check("rst.data", 64'(data), 64'd0);
        check("rst.src_mac", 64'(src_mac), 64'd0);
        check("rst.src_ip", 64'(src_ip), 64'd0);
        check("rst.src_port", 64'(src_port), 64'd0);

        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run("good", good_hdr(16'd12), -1, 1'b0, 1'b0, -1);
        run("bad_fcs", good_hdr(16'd12), -1, 1'b1, 1'b0, -1);
        h = good_hdr(16'd12);
        h.dport = 16'd5001;
        run("wrong_port", h, -1, 1'b0, 1'b0, -1);
        h = good_hdr(16'd12);
        h.smac = 48'hA0_B1_C2_D3_E4_F5;
        h.sip  = 32'hC0_A8_01_07;
        h.sport = 16'd777;
        run("good2", h, -1, 1'b0, 1'b0, -1);
        run("len265", good_hdr(16'd265), -1, 1'b0, 1'b0, -1);
        run("short2", good_hdr(16'd12), 2, 1'b0, 1'b0, -1);

        pay.delete();
        run("len8", good_hdr(16'd8), -1, 1'b0, 1'b0, -1);
        for (int i = 0; i < 256; i++) pay.push_back(8'($urandom));
        run("len264", good_hdr(16'd264), -1, 1'b0, 1'b0, -1);

        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        run("rst_hdr", good_hdr(16'd12), -1, 1'b0, 1'b0, 40);
        check("rst_hdr.src_mac", 64'(src_mac), 64'd0);
        check("rst_hdr.src_port", 64'(src_port), 64'd0);
        run("after_rst", good_hdr(16'd12), -1, 1'b0, 1'b0, -1);
        h = good_hdr(16'd12);
        h.dmac = 48'hFFFF_FFFF_FFFF;
        run("bcast", h, -1, 1'b0, 1'b0, -1);
        run("odd_nib", good_hdr(16'd12), -1, 1'b0, 1'b1, -1);

        for (int r = 0; r < 16; r++) begin
            h = good_hdr(16'(8 + $urandom_range(0, 40)));
            h.smac  = {16'h0000, 32'($urandom)};
            h.sip   = 32'($urandom);
            h.sport = 16'($urandom);
            pay.delete();
            for (int i = 0; i < int'(h.ulen) - 8; i++) pay.push_back(8'($urandom));
            kind = $urandom_range(0, 10);
            cp = -1;
            cor = 1'b0;
            odd = 1'b0;
            case (kind)
                0: h.dmac = LMAC ^ (48'd1 << $urandom_range(0, 47));
                1: h.dip = LIP ^ 32'h0000_0100;
                2: h.dport = LPORT + 16'd1;
                3: h.etype = 16'h86DD;
                4: h.verihl = 8'h46;
                5: h.proto = 8'd6;
                6: cor = 1'b1;
                7: if (h.ulen > 16'd8) cp = $urandom_range(0, int'(h.ulen) - 9);
                8: odd = 1'b1;
                9: h.dmac = 48'hFFFF_FFFF_FFFF;
                default: ;
            endcase
            run($sformatf("rnd%0d_k%0d", r, kind), h, cp, cor, odd, -1);
        end

        check("strobe_exclusive", 64'(clash_cnt), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
